// File: rtl/cam_stream_tx_pkg.sv
// Shared types and default timing for the camera stream transmitter.
// The frame FSM state enum lives here so the top, the timing generator and
// any checker bound to the debug state port all agree on one encoding.
package cam_pkg;

    // Frame phases, in the order a frame walks through them.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBP    = 3'd2,
        ST_LINE   = 3'd3,
        ST_HBLANK = 3'd4,
        ST_VFP    = 3'd5
    } cam_state_t;

    // Default VGA-like timing, all counted in Cam_pclk periods or lines.
    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_H_BLANK     = 144;
    localparam int DEF_VSYNC_LINES = 3;
    localparam int DEF_VBP_LINES   = 17;
    localparam int DEF_VFP_LINES   = 10;

    // Fixed bus widths towards the pixel source and the camera pins.
    localparam int PIX_ADDR_W = 19;
    localparam int PIX_W      = 16;
    localparam int BYTE_W     = 8;

    // Elaboration-time maximum, used to size the shared phase counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cam_stream_tx_if.sv
// Pixel-source read port plus the parallel camera output pins.
//
// Read port semantics (strobe, no back-pressure): Pix_rd_en is high for
// exactly one Clk with Pix_rd_addr valid in that same Clk; the source must
// present the addressed word on Pix_data during the following Clk, where the
// transmitter samples it. There is no ready; the source is assumed to always
// keep up. The camera pins are a free-running output with no handshake.
interface cam_stream_tx_if;
    import cam_pkg::*;

    logic                  Pix_rd_en;
    logic [PIX_ADDR_W-1:0] Pix_rd_addr;
    logic [PIX_W-1:0]      Pix_data;
    logic                  Cam_pclk;
    logic                  Cam_vsync;
    logic                  Cam_href;
    logic [BYTE_W-1:0]     Cam_data;

    // Transmitter side: drives the read strobe and the camera pins.
    modport master (
        output Pix_rd_en,
        output Pix_rd_addr,
        input  Pix_data,
        output Cam_pclk,
        output Cam_vsync,
        output Cam_href,
        output Cam_data
    );

    // Pixel source / camera receiver side.
    modport slave (
        input  Pix_rd_en,
        input  Pix_rd_addr,
        output Pix_data,
        input  Cam_pclk,
        input  Cam_vsync,
        input  Cam_href,
        input  Cam_data
    );

endinterface

// File: rtl/cam_stream_tx_timing_gen.sv
// Timing generator: Cam_pclk phase, the per-phase period (byte) counter and
// the line counter. It does not decide where the frame goes next; it only
// reports where the current phase ends, and exposes next-cycle counter
// values so the top can register its outputs for the period about to start.
module cam_timing_gen
    import cam_pkg::*;
#(
    parameter int VSYNC_LEN  = DEF_VSYNC_LINES * (2 * DEF_H_ACTIVE + DEF_H_BLANK),
    parameter int VBP_LEN    = DEF_VBP_LINES * (2 * DEF_H_ACTIVE + DEF_H_BLANK),
    parameter int LINE_LEN   = 2 * DEF_H_ACTIVE,
    parameter int HBLANK_LEN = DEF_H_BLANK,
    parameter int VFP_LEN    = DEF_VFP_LINES * (2 * DEF_H_ACTIVE + DEF_H_BLANK),
    parameter int CNT_W      = 15,
    parameter int LINE_W     = 9
) (
    input  logic              Clk,
    input  logic              Reset,
    input  cam_state_t        state_q,
    output logic              pclk,
    output logic              fall,
    output logic              phase_end,
    output logic [CNT_W-1:0]  cnt_d,
    output logic [LINE_W-1:0] line_q,
    output logic [LINE_W-1:0] line_d
);

    logic             pclk_q;
    logic             busy;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] len_m1;

    assign busy = (state_q != ST_IDLE);
    assign pclk = pclk_q;
    // Every period boundary is the Clk edge on which pclk goes high -> low.
    assign fall = busy && pclk_q;

    // Length of the current phase minus one, in Cam_pclk periods.
    always_comb begin
        len_m1 = '0;
        case (state_q)
            ST_VSYNC:  len_m1 = CNT_W'(VSYNC_LEN - 1);
            ST_VBP:    len_m1 = CNT_W'(VBP_LEN - 1);
            ST_LINE:   len_m1 = CNT_W'(LINE_LEN - 1);
            ST_HBLANK: len_m1 = CNT_W'(HBLANK_LEN - 1);
            ST_VFP:    len_m1 = CNT_W'(VFP_LEN - 1);
            default:   len_m1 = '0;
        endcase
    end

    assign phase_end = fall && (cnt_q == len_m1);

    // Period counter restarts at every phase boundary; it never wraps inside
    // a phase because it is cleared exactly at the phase's last period.
    always_comb begin
        cnt_d = cnt_q;
        if (!busy) begin
            cnt_d = '0;
        end else if (fall) begin
            cnt_d = phase_end ? '0 : cnt_q + 1'b1;
        end
    end

    // Lines sent this frame: cleared before the active region, bumped as
    // each active line finishes.
    always_comb begin
        line_d = line_q;
        if (state_q == ST_IDLE || state_q == ST_VSYNC) begin
            line_d = '0;
        end else if (state_q == ST_LINE && phase_end) begin
            line_d = line_q + 1'b1;
        end
    end

    // pclk toggles every Clk while a frame is running, parked low otherwise.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pclk_q <= 1'b0;
        end else begin
            pclk_q <= busy ? ~pclk_q : 1'b0;
        end
    end

    // Counter registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            line_q <= line_d;
        end
    end

endmodule

// File: rtl/cam_stream_tx.sv
// Camera stream transmitter: reads RGB565 pixels from a one-cycle-latency
// source and serialises them as an 8-bit DVP-style stream with vsync/href,
// Cam_pclk at Clk/2. All camera pins update only on the Clk edge that drives
// Cam_pclk low, so a receiver sampling on the rising edge sees stable data.
module cam_stream_tx
    import cam_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int H_BLANK     = DEF_H_BLANK,
    parameter int VSYNC_LINES = DEF_VSYNC_LINES,
    parameter int VBP_LINES   = DEF_VBP_LINES,
    parameter int VFP_LINES   = DEF_VFP_LINES
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Run,
    cam_stream_tx_if.master bus,
    output logic            Frame_done,
    output logic            Busy,
    output cam_state_t      Dbg_state
);

    localparam int LT         = 2 * H_ACTIVE + H_BLANK;
    localparam int VSYNC_LEN  = VSYNC_LINES * LT;
    localparam int VBP_LEN    = VBP_LINES * LT;
    localparam int LINE_LEN   = 2 * H_ACTIVE;
    localparam int HBLANK_LEN = H_BLANK;
    localparam int VFP_LEN    = VFP_LINES * LT;
    localparam int MAX_LEN    = max_int(max_int(max_int(VSYNC_LEN, VBP_LEN),
                                                max_int(LINE_LEN, HBLANK_LEN)),
                                        VFP_LEN);
    localparam int CNT_W      = $clog2(MAX_LEN + 1);
    localparam int LINE_W     = $clog2(V_ACTIVE + 1);
    localparam int NPIX       = H_ACTIVE * V_ACTIVE;
    localparam int PIX_IDX_W  = $clog2(NPIX + 1);

    cam_state_t state_q;
    cam_state_t state_d;

    logic              pclk;
    logic              fall;
    logic              phase_end;
    logic [CNT_W-1:0]  cnt_d;
    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] line_d;

    logic              start;
    logic              upd;
    logic              fetch;
    logic              fetch_go;
    logic [BYTE_W-1:0] data_d;

    logic                  vsync_q;
    logic                  href_q;
    logic [BYTE_W-1:0]     data_q;
    logic                  rd_en_q;
    logic [PIX_ADDR_W-1:0] rd_addr_q;
    logic                  rd_pend_q;
    logic [BYTE_W-1:0]     pix_lo_q;
    logic [PIX_IDX_W-1:0]  pix_idx_q;
    logic                  done_q;

    cam_timing_gen #(
        .VSYNC_LEN  (VSYNC_LEN),
        .VBP_LEN    (VBP_LEN),
        .LINE_LEN   (LINE_LEN),
        .HBLANK_LEN (HBLANK_LEN),
        .VFP_LEN    (VFP_LEN),
        .CNT_W      (CNT_W),
        .LINE_W     (LINE_W)
    ) u_timing (
        .Clk       (Clk),
        .Reset     (Reset),
        .state_q   (state_q),
        .pclk      (pclk),
        .fall      (fall),
        .phase_end (phase_end),
        .cnt_d     (cnt_d),
        .line_q    (line_q),
        .line_d    (line_d)
    );

    // A new Cam_pclk period starts either on a falling pclk edge or on the
    // edge that leaves IDLE (pclk is already low there).
    assign start = (state_q == ST_IDLE) && Run;
    assign upd   = start || fall;

    // Next frame phase; Run is only looked at in IDLE and at the end of VFP,
    // so dropping it mid-frame never truncates a frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (Run)       state_d = ST_VSYNC;
            ST_VSYNC:  if (phase_end) state_d = ST_VBP;
            ST_VBP:    if (phase_end) state_d = ST_LINE;
            ST_LINE:   if (phase_end) state_d = ST_HBLANK;
            ST_HBLANK: if (phase_end) state_d = (line_q < LINE_W'(V_ACTIVE)) ? ST_LINE : ST_VFP;
            ST_VFP:    if (phase_end) state_d = Run ? ST_VSYNC : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs for the period about to start. A pixel is fetched in the
    // period just before its high byte: the last period ahead of a line, and
    // each odd (low-byte) period of a line except the final one.
    always_comb begin
        fetch    = 1'b0;
        fetch_go = 1'b0;
        data_d   = '0;
        case (state_d)
            ST_VBP:    fetch = (cnt_d == CNT_W'(VBP_LEN - 1));
            ST_LINE:   fetch = cnt_d[0] && (cnt_d < CNT_W'(LINE_LEN - 1));
            ST_HBLANK: fetch = (cnt_d == CNT_W'(HBLANK_LEN - 1)) &&
                               (line_d < LINE_W'(V_ACTIVE));
            default:   fetch = 1'b0;
        endcase
        fetch_go = upd && fetch;
        // High byte straight off the source bus (it is valid on exactly this
        // edge); low byte from the word captured on that same edge earlier.
        if (state_d == ST_LINE) begin
            data_d = cnt_d[0] ? pix_lo_q : bus.Pix_data[15:8];
        end
    end

    // Frame FSM state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pixel fetch: strobe, address, and capture of the returned word.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_pend_q <= 1'b0;
            pix_lo_q  <= '0;
            pix_idx_q <= '0;
        end else begin
            rd_en_q   <= fetch_go;
            rd_pend_q <= rd_en_q;
            if (rd_pend_q) begin
                pix_lo_q <= bus.Pix_data[7:0];
            end
            if (fetch_go) begin
                rd_addr_q <= PIX_ADDR_W'(pix_idx_q);
                pix_idx_q <= pix_idx_q + 1'b1;
            end else if (state_q == ST_IDLE || state_q == ST_VSYNC) begin
                pix_idx_q <= '0;
            end
        end
    end

    // Camera pins, updated only at period starts; Frame_done as a pulse.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            if (upd) begin
                vsync_q <= (state_d == ST_VSYNC);
                href_q  <= (state_d == ST_LINE);
                data_q  <= data_d;
            end
            done_q <= (state_q == ST_VFP) && phase_end;
        end
    end

    assign bus.Cam_pclk    = pclk;
    assign bus.Cam_vsync   = vsync_q;
    assign bus.Cam_href    = href_q;
    assign bus.Cam_data    = data_q;
    assign bus.Pix_rd_en   = rd_en_q;
    assign bus.Pix_rd_addr = rd_addr_q;
    assign Frame_done      = done_q;
    assign Busy            = (state_q != ST_IDLE);
    assign Dbg_state       = state_q;

endmodule

// File: tb/tb_cam_stream_tx.sv
// Bench for cam_stream_tx with a small frame (4x2 pixels, LT = 10 periods).
// The reference model builds each frame as a list of per-period pin values
// straight from the frame layout, and a pixel memory answers read strobes.
module tb_cam_stream_tx;
    import cam_pkg::*;

    localparam int H    = 4;
    localparam int V    = 2;
    localparam int HB   = 2;
    localparam int VSL  = 1;
    localparam int VBPL = 1;
    localparam int VFPL = 1;
    localparam int LT   = 2 * H + HB;
    localparam int NPIX = H * V;

    // ---------------- clock / reset ----------------
    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    logic Run   = 1'b0;
    logic Frame_done;
    logic Busy;
    cam_state_t dbg_state;

    always #5 Clk = ~Clk;

    cam_stream_tx_if bus();

    cam_stream_tx #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .H_BLANK     (HB),
        .VSYNC_LINES (VSL),
        .VBP_LINES   (VBPL),
        .VFP_LINES   (VFPL)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Run        (Run),
        .bus        (bus.master),
        .Frame_done (Frame_done),
        .Busy       (Busy),
        .Dbg_state  (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [9:0]  exp_q[$];          // {vsync, href, data} per Cam_pclk period
    logic [15:0] mem[NPIX];
    int          exp_addr = 0;
    logic        prev_pclk = 1'b0;
    logic        prev_rd   = 1'b0;
    logic [9:0]  prev_out  = '0;
    logic [9:0]  mon_cur;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected pin values for one whole frame, period by period.
    function automatic void push_frame();
        for (int i = 0; i < VSL * LT; i++) exp_q.push_back({1'b1, 1'b0, 8'h00});
        for (int i = 0; i < VBPL * LT; i++) exp_q.push_back(10'h000);
        for (int l = 0; l < V; l++) begin
            for (int b = 0; b < 2 * H; b++) begin
                logic [15:0] w;
                w = mem[l * H + b / 2];
                exp_q.push_back({1'b0, 1'b1, (b % 2 == 0) ? w[15:8] : w[7:0]});
            end
            for (int i = 0; i < HB; i++) exp_q.push_back(10'h000);
        end
        for (int i = 0; i < VFPL * LT; i++) exp_q.push_back(10'h000);
    endfunction

    // Pixel source: addressed word one Clk after the strobe, junk otherwise.
    always @(posedge Clk) begin
        bus.Pix_data <= bus.Pix_rd_en ? mem[int'(bus.Pix_rd_addr) % NPIX] : 16'($urandom);
    end

    // Monitor: low-half vs high-half stability, per-period compare, fetches.
    always @(negedge Clk) begin
        mon_cur = {bus.Cam_vsync, bus.Cam_href, bus.Cam_data};
        if (Reset) begin
            prev_pclk = 1'b0;
            prev_rd   = 1'b0;
            prev_out  = '0;
        end else begin
            if (bus.Pix_rd_en) begin
                check_eq("rd_1clk", 32'(prev_rd), 32'(0));
                check_eq("rd_addr", 32'(bus.Pix_rd_addr), 32'(exp_addr));
                exp_addr = (exp_addr + 1) % NPIX;
            end
            if (!Busy) check_eq("idle_pclk", 32'(bus.Cam_pclk), 32'(0));
            if (bus.Cam_pclk && !prev_pclk) begin
                check_eq("stable", 32'(mon_cur), 32'(prev_out));
                check_eq("busy", 32'(Busy), 32'(1));
                check_eq("period_avail", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) check_eq("period", 32'(mon_cur), 32'(exp_q.pop_front()));
            end
            prev_pclk = bus.Cam_pclk;
            prev_rd   = bus.Pix_rd_en;
            prev_out  = mon_cur;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic fill_mem(input bit addr_pattern);
        for (int i = 0; i < NPIX; i++) mem[i] = addr_pattern ? 16'(16'hA000 + i) : 16'($urandom);
    endtask

    // Returns at the negedge where Frame_done is high, or after the budget.
    task automatic wait_done(input int budget);
        int seen;
        seen = 0;
        for (int i = 0; i < budget && seen == 0; i++) begin
            @(negedge Clk);
            if (Frame_done) seen = 1;
        end
        check_eq("done_seen", 32'(seen), 32'(1));
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
        check_eq({tag, "_busy"}, 32'(Busy), 32'(0));
        check_eq({tag, "_pclk"}, 32'(bus.Cam_pclk), 32'(0));
        check_eq({tag, "_vsync"}, 32'(bus.Cam_vsync), 32'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_pclk"}, 32'(bus.Cam_pclk), 32'(0));
        check_eq({tag, "_vsync"}, 32'(bus.Cam_vsync), 32'(0));
        check_eq({tag, "_href"}, 32'(bus.Cam_href), 32'(0));
        check_eq({tag, "_data"}, 32'(bus.Cam_data), 32'(0));
        check_eq({tag, "_rd_en"}, 32'(bus.Pix_rd_en), 32'(0));
        check_eq({tag, "_addr"}, 32'(bus.Pix_rd_addr), 32'(0));
        check_eq({tag, "_done"}, 32'(Frame_done), 32'(0));
        check_eq({tag, "_busy"}, 32'(Busy), 32'(0));
        check_eq({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // One frame started by a short Run pulse, Run dropped after k Clks.
    task automatic run_one_frame(input int k);
        push_frame();
        Run = 1'b1;
        repeat (k) @(negedge Clk);
        Run = 1'b0;
        wait_done(300);
        check_idle("end");
        repeat (4) @(negedge Clk);
        check_eq("q_empty", 32'(exp_q.size()), 32'(0));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int seen;
        fill_mem(1'b1);
        Reset = 1'b1;
        Run   = 1'b0;
        repeat (3) @(negedge Clk);
        check_all_zero("rst");
        Reset = 1'b0;
        repeat (6) @(negedge Clk);
        check_idle("no_run");

        // Address-patterned frame: line 0 bytes A0,00,A0,01,A0,02,A0,03.
        run_one_frame(1);
        check_eq("addr_wrap", 32'(exp_addr), 32'(0));

        // Back-to-back frames with Run held, dropped during line 1 of frame 2.
        fill_mem(1'b0);
        push_frame();
        push_frame();
        Run = 1'b1;
        wait_done(300);
        check_eq("b2b_vsync", 32'(bus.Cam_vsync), 32'(1));
        check_eq("b2b_state", 32'(dbg_state), 32'(ST_VSYNC));
        check_eq("b2b_busy", 32'(Busy), 32'(1));
        repeat ($urandom_range(62, 74)) @(negedge Clk);
        check_eq("drop_in_line", 32'(bus.Cam_href || dbg_state == ST_LINE || dbg_state == ST_HBLANK), 32'(1));
        Run = 1'b0;
        wait_done(300);
        check_idle("b2b_end");
        repeat (4) @(negedge Clk);
        check_eq("b2b_q_empty", 32'(exp_q.size()), 32'(0));

        // Random data, random Run width and idle gaps.
        for (int n = 0; n < 3; n++) begin
            fill_mem(1'b0);
            repeat ($urandom_range(0, 7)) @(negedge Clk);
            run_one_frame($urandom_range(1, 90));
        end

        // Reset in the middle of an active line, then a clean frame.
        fill_mem(1'b0);
        push_frame();
        Run = 1'b1;
        @(negedge Clk);
        Run = 1'b0;
        seen = 0;
        for (int i = 0; i < 200 && seen == 0; i++) begin
            @(negedge Clk);
            if (bus.Cam_href) seen = 1;
        end
        check_eq("href_seen", 32'(seen), 32'(1));
        repeat ($urandom_range(0, 3)) @(negedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        check_all_zero("mid_rst");
        exp_q.delete();
        exp_addr = 0;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        run_one_frame(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
